// File: rtl/i_stream_buffer_if.sv
// Bundles the i-cache request/return channels and the memory burst channels.
interface i_stream_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic                  m_arvalid;
    logic                  m_arready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_rvalid;
    logic                  m_rready;

    // The buffer itself: serves the i-cache, drives memory.
    modport slave (
        input  s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rvalid,
        output s_arready, s_rdata, s_rvalid, m_araddr, m_arlen, m_arvalid, m_rready
    );

    // The surroundings: i-cache and memory together.
    modport master (
        output s_araddr, s_arvalid, s_rready, m_arready, m_rdata, m_rvalid,
        input  s_arready, s_rdata, s_rvalid, m_araddr, m_arlen, m_arvalid, m_rready
    );
endinterface

// File: rtl/i_stream_buffer.sv
// One-line next-line stream buffer in front of the i-cache refill path: hits stream from the
// buffer one cycle after acceptance, misses pass memory beats through; every demand triggers a prefetch.
module i_stream_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    i_stream_buffer_if.slave bus,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + $clog2(DATA_WIDTH / 8);
    localparam int LW  = ADDR_WIDTH - OFF;

    localparam logic [BW-1:0] ONE_BEAT  = 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [LW-1:0] ONE_LINE  = 1;

    typedef enum logic [2:0] {
        IDLE,
        HIT_STREAM,
        MISS_REQ,
        MISS_DATA,
        PF_REQ,
        PF_DATA
    } state_t;

    state_t                state;
    logic [BW-1:0]         beat;
    logic [LW-1:0]         buf_addr;
    logic                  buf_valid;
    logic [LW-1:0]         demand_line;
    logic [LW-1:0]         pf_addr;
    logic [DATA_WIDTH-1:0] words [LINE_WORDS];

    logic [LW-1:0] req_line;
    logic          hit;
    logic          beat_last;

    assign req_line  = bus.s_araddr[ADDR_WIDTH-1:OFF];
    assign hit       = buf_valid && (req_line == buf_addr);
    assign beat_last = (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            buf_valid   <= 1'b0;
            buf_addr    <= '0;
            demand_line <= '0;
            pf_addr     <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_arvalid) begin
                        demand_line <= req_line;
                        beat        <= '0;
                        if (hit) begin
                            // Buffer is consumed by this hit; its words stay readable while streaming.
                            state     <= HIT_STREAM;
                            buf_valid <= 1'b0;
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            state <= MISS_REQ;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                HIT_STREAM: begin
                    if (bus.s_rready) begin
                        if (beat_last) begin
                            state   <= PF_REQ;
                            beat    <= '0;
                            pf_addr <= demand_line + ONE_LINE;
                        end else begin
                            beat <= beat + ONE_BEAT;
                        end
                    end
                end
                MISS_REQ: begin
                    if (bus.m_arready) begin
                        state <= MISS_DATA;
                        beat  <= '0;
                    end
                end
                MISS_DATA: begin
                    if (bus.m_rvalid && bus.s_rready) begin
                        if (beat_last) begin
                            state   <= PF_REQ;
                            beat    <= '0;
                            pf_addr <= demand_line + ONE_LINE;
                        end else begin
                            beat <= beat + ONE_BEAT;
                        end
                    end
                end
                PF_REQ: begin
                    if (bus.m_arready) begin
                        state <= PF_DATA;
                        beat  <= '0;
                    end
                end
                PF_DATA: begin
                    if (bus.m_rvalid) begin
                        if (beat_last) begin
                            state     <= IDLE;
                            beat      <= '0;
                            buf_addr  <= pf_addr;
                            buf_valid <= 1'b1;
                        end else begin
                            beat <= beat + ONE_BEAT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    // Line storage carries no reset; buf_valid alone guards its contents.
    always_ff @(posedge clk) begin
        if (state == PF_DATA && bus.m_rvalid) begin
            words[beat] <= bus.m_rdata;
        end
    end

    always_comb begin
        bus.s_arready = (state == IDLE);
        bus.s_rvalid  = 1'b0;
        bus.s_rdata   = '0;
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = {demand_line, {OFF{1'b0}}};
        bus.m_arlen   = 8'(LINE_WORDS);
        bus.m_rready  = 1'b0;
        case (state)
            HIT_STREAM: begin
                bus.s_rvalid = 1'b1;
                bus.s_rdata  = words[beat];
            end
            MISS_REQ: begin
                bus.m_arvalid = 1'b1;
            end
            MISS_DATA: begin
                bus.s_rvalid = bus.m_rvalid;
                bus.s_rdata  = bus.m_rdata;
                bus.m_rready = bus.s_rready;
            end
            PF_REQ: begin
                bus.m_arvalid = 1'b1;
                bus.m_araddr  = {pf_addr, {OFF{1'b0}}};
            end
            PF_DATA: begin
                bus.m_rready = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/i_stream_buffer.md
I_STREAM_BUFFER -- requirements
Module: i_stream_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning words per cache line and burst beats; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning beat and word width.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 s_araddr  input  ADDR_WIDTH  i-cache line request address; offset bits ignored.
REQ-007 s_arvalid / s_arready  input / output  1  i-cache request handshake.
REQ-008 s_rdata / s_rvalid / s_rready  output / output / input  DATA_WIDTH / 1 / 1  beats returned to the i-cache.
REQ-009 m_araddr / m_arlen  output / output  ADDR_WIDTH / 8  memory request; m_arlen = LINE_WORDS beats (a beat count, not count-1).
REQ-010 m_arvalid / m_arready  output / input  1  memory request handshake.
REQ-011 m_rdata / m_rvalid / m_rready  input / input / output  DATA_WIDTH / 1 / 1  memory beats.
REQ-012 hit_count / miss_count  output / output  16 / 16  saturating statistics counters.

Function
REQ-013 SHALL hold one line buffer with: line address buf_addr (ADDR_WIDTH minus offset bits), LINE_WORDS data words, and buf_valid.
REQ-014 SHALL implement states IDLE, HIT_STREAM, MISS_REQ, MISS_DATA, PF_REQ, and PF_DATA.
REQ-015 SHALL assert s_arready only in IDLE; a request is accepted when s_arvalid and s_arready are both high.
REQ-016 Hit = buf_valid and s_araddr line address == buf_addr. On an accepted hit SHALL go IDLE->HIT_STREAM and set buf_valid to 0.
REQ-017 On an accepted miss SHALL go IDLE->MISS_REQ, latch the request line address, and leave the buffer unchanged.
REQ-018 In HIT_STREAM SHALL present buffer word[beat] on s_rdata with s_rvalid=1, starting the cycle after acceptance; beat advances only when s_rready=1.
REQ-019 In HIT_STREAM, after LINE_WORDS accepted beats, SHALL go to PF_REQ.
REQ-020 MISS_REQ SHALL drive m_arvalid=1 and m_araddr = latched line address with zero offset; on m_arready SHALL go to MISS_DATA.
REQ-021 MISS_DATA SHALL pass through combinationally: s_rdata=m_rdata, s_rvalid=m_rvalid, m_rready=s_rready.
REQ-022 In MISS_DATA, after LINE_WORDS beats with m_rvalid and m_rready both high, SHALL go to PF_REQ.
REQ-023 On entering PF_REQ SHALL set pf_addr = (demand line address + 1) mod 2^(line address width); the top line wraps to line 0.
REQ-024 PF_REQ SHALL drive m_arvalid=1 and m_araddr = pf_addr with zero offset; on m_arready SHALL go to PF_DATA.
REQ-025 PF_DATA SHALL drive m_rready=1 and write m_rdata into word[beat] on each valid beat; s_rvalid=0.
REQ-026 On the last PF_DATA beat SHALL set buf_addr=pf_addr and buf_valid=1, then go to IDLE.
REQ-027 Requests arriving in any non-IDLE state SHALL stall (s_arready=0) until IDLE; the i-cache holds s_arvalid.
REQ-028 A single beat counter (log2 LINE_WORDS bits) SHALL count beats and clear on every state exit.
REQ-029 hit_count SHALL increment by 1 per accepted hit, and miss_count by 1 per accepted miss; each holds at 16'hFFFF.
REQ-030 s_rvalid SHALL be 0 outside HIT_STREAM and MISS_DATA, and m_arvalid SHALL be 0 outside MISS_REQ and PF_REQ.
REQ-031 m_rready SHALL be 0 in IDLE, HIT_STREAM, MISS_REQ, and PF_REQ.
REQ-032 Minimum latency from request acceptance to first s_rvalid SHALL be 1 cycle on a hit, and 1 cycle plus memory latency on a miss.

Reset
REQ-033 When rst_n=0 at posedge, SHALL set: state=IDLE, buf_valid=0, beat=0, hit_count=0, miss_count=0.
REQ-034 During and after reset, outputs SHALL be s_arready=1 (IDLE), s_rvalid=0, m_arvalid=0, m_rready=0.
REQ-035 Reset mid-burst SHALL abandon the burst and discard any partial prefetch; memory shares rst_n, so no stale beats arrive after reset.
REQ-036 Buffer data words need not be reset.

Verification
REQ-037 Cold miss: request 0x0000_0100, LINE_WORDS=4 -> m_araddr=0x100, m_arlen=4; 4 beats pass through; then prefetch m_araddr=0x110; buf_valid=1; miss_count=1.
REQ-038 Sequential hit: after REQ-037, request 0x0000_0114 -> no memory request; 4 beats of line 0x110 returned starting next cycle; then prefetch 0x120; hit_count=1.
REQ-039 Non-sequential: after REQ-037, request 0x0000_0400 -> miss; buffer holding 0x110 stays unused; prefetch 0x410 follows.
REQ-040 Wrap: request 0xFFFF_FFF0 -> miss, then prefetch m_araddr=0x0000_0000.
REQ-041 Backpressure: hold m_arready=0 for 5 cycles, insert m_rvalid gaps, and toggle s_rready -> no lost or duplicated beat; data order is preserved.
REQ-042 Reset during PF_DATA after 2 beats, then request the prefetched line -> miss, since buf_valid=0; counters read 0 after reset.
